stim_spi_cmd_decoder: RTL and testbench

Receive-side counterpart of the stimulator's 4-lane command SPI link. Oversamples SCLK/CSb/MOSI[3:0]/TRG_SLV/RST_SLV in the local CLK domain, deserializes one 16-bit command per lane per frame, and holds the decoded writes as pending. On TRG_SLV it applies them to a 4×32 amplitude register file and to the bias registers. It serves as the probe-side command decoder and as a loopback checker for the transmitter.

---
 rtl/stim_spi_cmd_decoder.sv | 162 ++++++++++++++++
 tb/tb_stim_spi_cmd_decoder.sv | 168 ++++++++++++++++
 2 files changed

// File: rtl/stim_spi_cmd_decoder.sv
// stim_spi_cmd_decoder: 4-lane command SPI receiver with pending writes applied on trigger
module stim_spi_cmd_decoder #(
    parameter int CMD_W       = 16,
    parameter int SYNC_STAGES = 2
) (
    input  logic         CLK_i,
    input  logic         RST_i,
    input  logic         SCLK_i,
    input  logic         CSb_i,
    input  logic         RST_SLV_i,
    input  logic         TRG_SLV_i,
    input  logic [3:0]   MOSI_i,
    input  logic [1:0]   RD_LANE_i,
    input  logic [4:0]   RD_ADDR_i,
    output logic [7:0]   RD_AMP_o,
    output logic [127:0] ACTIVE_o,
    output logic         BIAS_SEL_o,
    output logic [6:0]   BIAS_AMP_o,
    output logic         WORD_VALID_o,
    output logic         APPLY_o,
    output logic         FRAME_ERR_o,
    output logic [7:0]   ERR_CNT_o
);
    localparam int CW = $clog2(CMD_W + 2);
    localparam logic [CW-1:0] FULL = CW'(CMD_W);
    localparam logic [CW-1:0] OVF  = CW'(CMD_W + 1);

    typedef enum logic [1:0] {IDLE, SHIFT, COMMIT} state_t;

    logic [SYNC_STAGES-1:0][7:0] sync_q;
    logic [2:0]                  prev_q;
    logic [7:0]                  s;
    logic                        sclk_rise, csb_fall, csb_rise, trg_rise, srst, commit;
    logic [3:0]                  mosi_s;

    state_t                      state_q;
    logic [CW-1:0]               cnt_q;
    logic [3:0][CMD_W-1:0]       sh_q;
    logic                        wv_q, fe_q;
    logic [7:0]                  err_q;

    logic [3:0]                  pv_q, pv_d;
    logic [3:0][CMD_W-1:0]       pw_q, pw_d;
    logic                        bv_q, bv_d;
    logic [7:0]                  bw_q, bw_d, bias_q;
    logic [3:0][31:0][7:0]       rf_q, rf_d;
    logic [7:0]                  rd_q;
    logic [127:0]                active_q, active_d;
    logic                        apply_q;

    assign s         = sync_q[SYNC_STAGES-1];
    assign mosi_s    = s[7:4];
    assign srst      = s[3];
    assign sclk_rise = s[0] & ~prev_q[0];
    assign csb_fall  = ~s[1] & prev_q[1];
    assign csb_rise  = s[1] & ~prev_q[1];
    assign trg_rise  = s[2] & ~prev_q[2];
    // A well-formed frame is latched into the pending slots on the detected CSb rise, so a
    // trigger detected in that same cycle already sees the new words.
    assign commit    = (state_q == SHIFT) && csb_rise && (cnt_q == FULL);

    // Synchronizer chains for every link input plus one edge-detect stage
    always_ff @(posedge CLK_i) begin
        if (!RST_i) begin
            sync_q <= '0;
            prev_q <= '0;
        end else begin
            sync_q[0] <= {MOSI_i, RST_SLV_i, TRG_SLV_i, CSb_i, SCLK_i};
            for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
            prev_q <= s[2:0];
        end
    end

    // Frame FSM: shift lanes on SCLK rises, judge the bit count on CSb rise
    always_ff @(posedge CLK_i) begin
        if (!RST_i || srst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            sh_q    <= '0;
            wv_q    <= 1'b0;
            fe_q    <= 1'b0;
            if (!RST_i) err_q <= '0;
        end else begin
            wv_q <= 1'b0;
            fe_q <= 1'b0;
            case (state_q)
                IDLE: if (csb_fall) begin
                    state_q <= SHIFT;
                    cnt_q   <= '0;
                    sh_q    <= '0;
                end
                SHIFT: if (csb_rise) begin
                    state_q <= COMMIT;
                    wv_q    <= cnt_q == FULL;
                    fe_q    <= cnt_q != FULL;
                    if (cnt_q != FULL && err_q != 8'hFF) err_q <= err_q + 8'd1;
                end else if (sclk_rise && !s[1]) begin
                    for (int n = 0; n < 4; n++) sh_q[n] <= {sh_q[n][CMD_W-2:0], mosi_s[n]};
                    cnt_q <= (cnt_q == OVF) ? OVF : cnt_q + 1'b1;
                end
                default: begin
                    state_q <= csb_fall ? SHIFT : IDLE;
                    cnt_q   <= '0;
                    sh_q    <= '0;
                end
            endcase
        end
    end

    // Next pending state (commit merged first) and register-file writes on trigger
    always_comb begin
        rf_d = rf_q;
        bv_d = bv_q | (commit & ~sh_q[0][CMD_W-1]);
        bw_d = (commit && !sh_q[0][CMD_W-1]) ? {sh_q[0][CMD_W-2], sh_q[0][6:0]} : bw_q;
        for (int n = 0; n < 4; n++) begin
            pv_d[n] = pv_q[n] | (commit & sh_q[n][CMD_W-1]);
            pw_d[n] = (commit && sh_q[n][CMD_W-1]) ? sh_q[n] : pw_q[n];
            if (trg_rise && pv_d[n]) rf_d[n][pw_d[n][CMD_W-2 -: 5]] = pw_d[n][7:0];
        end
    end

    // Per-entry nonzero flags for the ACTIVE map
    always_comb begin
        active_d = '0;
        for (int l = 0; l < 4; l++)
            for (int a = 0; a < 32; a++) active_d[l*32+a] = |rf_q[l][a];
    end

    // Pending slots, register file, bias, write-first readback and ACTIVE
    always_ff @(posedge CLK_i) begin
        if (!RST_i || srst) begin
            pv_q     <= '0;
            pw_q     <= '0;
            bv_q     <= 1'b0;
            bw_q     <= '0;
            bias_q   <= '0;
            rf_q     <= '0;
            rd_q     <= '0;
            active_q <= '0;
            apply_q  <= 1'b0;
        end else begin
            pv_q     <= trg_rise ? 4'h0 : pv_d;
            pw_q     <= pw_d;
            bv_q     <= bv_d & ~trg_rise;
            bw_q     <= bw_d;
            bias_q   <= (trg_rise && bv_d) ? bw_d : bias_q;
            rf_q     <= rf_d;
            rd_q     <= rf_d[RD_LANE_i][RD_ADDR_i];
            active_q <= active_d;
            apply_q  <= trg_rise;
        end
    end

    assign RD_AMP_o     = rd_q;
    assign ACTIVE_o     = active_q;
    assign BIAS_SEL_o   = bias_q[7];
    assign BIAS_AMP_o   = bias_q[6:0];
    assign WORD_VALID_o = wv_q;
    assign APPLY_o      = apply_q;
    assign FRAME_ERR_o  = fe_q;
    assign ERR_CNT_o    = err_q;
endmodule

// File: tb/tb_stim_spi_cmd_decoder.sv
// tb_stim_spi_cmd_decoder: directed self-checking bench for the command SPI decoder
module tb_stim_spi_cmd_decoder;
    logic         CLK = 1'b0, RST = 1'b0, SCLK = 1'b0, CSb = 1'b1, RST_SLV = 1'b0, TRG = 1'b0;
    logic [3:0]   MOSI = 4'h0;
    logic [1:0]   RD_LANE = 2'd0;
    logic [4:0]   RD_ADDR = 5'd0;
    logic [7:0]   RD_AMP, ERR_CNT;
    logic [127:0] ACTIVE;
    logic         BIAS_SEL, WORD_VALID, APPLY, FRAME_ERR;
    logic [6:0]   BIAS_AMP;
    int vectors = 0, miscompares = 0;
    int wv_cnt = 0, fe_cnt = 0, ap_cnt = 0;
    int wv0, fe0, ap0;
    logic [7:0] rv;

    stim_spi_cmd_decoder dut (
        .CLK_i(CLK), .RST_i(RST), .SCLK_i(SCLK), .CSb_i(CSb), .RST_SLV_i(RST_SLV),
        .TRG_SLV_i(TRG), .MOSI_i(MOSI), .RD_LANE_i(RD_LANE), .RD_ADDR_i(RD_ADDR),
        .RD_AMP_o(RD_AMP), .ACTIVE_o(ACTIVE), .BIAS_SEL_o(BIAS_SEL), .BIAS_AMP_o(BIAS_AMP),
        .WORD_VALID_o(WORD_VALID), .APPLY_o(APPLY), .FRAME_ERR_o(FRAME_ERR), .ERR_CNT_o(ERR_CNT)
    );

    always #5 CLK = ~CLK;

    always @(posedge CLK) begin
        if (WORD_VALID) wv_cnt <= wv_cnt + 1;
        if (FRAME_ERR) fe_cnt <= fe_cnt + 1;
        if (APPLY) ap_cnt <= ap_cnt + 1;
    end

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic mark();
        wv0 = wv_cnt; fe0 = fe_cnt; ap0 = ap_cnt;
    endtask

    task automatic send_frame(input logic [15:0] w0, w1, w2, w3, input int nbits, input bit trg);
        logic [15:0] l0, l1, l2, l3;
        l0 = w0; l1 = w1; l2 = w2; l3 = w3;
        CSb = 1'b0;
        #80;
        for (int i = 0; i < nbits; i++) begin
            MOSI = {l3[15], l2[15], l1[15], l0[15]};
            l0 = l0 << 1; l1 = l1 << 1; l2 = l2 << 1; l3 = l3 << 1;
            #40 SCLK = 1'b1;
            #40 SCLK = 1'b0;
        end
        #40 CSb = 1'b1;
        if (trg) TRG = 1'b1;
        #100 TRG = 1'b0;
        #60;
    endtask

    task automatic trigger();
        TRG = 1'b1;
        #60 TRG = 1'b0;
        #60;
    endtask

    task automatic rd(input logic [1:0] lane, input logic [4:0] addr, output logic [7:0] v);
        RD_LANE = lane; RD_ADDR = addr;
        #20 v = RD_AMP;
    endtask

    initial begin
        @(negedge CLK);
        #30;
        chk("rst_active", ACTIVE, '0);
        chk("rst_errcnt", ERR_CNT, 0);
        chk("rst_rdamp", RD_AMP, 0);
        chk("rst_bias", {BIAS_SEL, BIAS_AMP}, 0);
        chk("rst_pulses", {WORD_VALID, APPLY, FRAME_ERR}, 0);
        RST = 1'b1;
        #50;
        // amplitude write: lane0 addr3 amp 0x2A
        mark();
        send_frame(16'h8C2A, 16'h8000, 16'h8000, 16'h8000, 16, 1'b0);
        chk("amp_wv", wv_cnt - wv0, 1);
        chk("amp_fe", fe_cnt - fe0, 0);
        chk("amp_pending_not_applied", ACTIVE, '0);
        trigger();
        chk("amp_apply", ap_cnt - ap0, 1);
        rd(2'd0, 5'd3, rv);
        chk("amp_rf03", rv, 8'h2A);
        chk("amp_active", ACTIVE, 128'h8);
        // bias write
        mark();
        send_frame(16'h4055, 16'h0000, 16'h0000, 16'h0000, 16, 1'b0);
        trigger();
        chk("bias_sel", BIAS_SEL, 1'b1);
        chk("bias_amp", BIAS_AMP, 7'h55);
        chk("bias_active", ACTIVE, 128'h8);
        chk("bias_apply", ap_cnt - ap0, 1);
        // bad frame lengths
        mark();
        send_frame(16'h8C55, 16'h8000, 16'h8000, 16'h8000, 15, 1'b0);
        send_frame(16'h8C55, 16'h8000, 16'h8000, 16'h8000, 17, 1'b0);
        chk("bad_fe", fe_cnt - fe0, 2);
        chk("bad_wv", wv_cnt - wv0, 0);
        chk("bad_errcnt", ERR_CNT, 2);
        trigger();
        rd(2'd0, 5'd3, rv);
        chk("bad_rf03", rv, 8'h2A);
        chk("bad_active", ACTIVE, 128'h8);
        chk("bad_bias", {BIAS_SEL, BIAS_AMP}, {1'b1, 7'h55});
        chk("bad_apply", ap_cnt - ap0, 1);
        // overwrite before apply: lane1 addr7 0x10 then 0x20
        send_frame(16'h8000, 16'h9C10, 16'h8000, 16'h8000, 16, 1'b0);
        send_frame(16'h8000, 16'h9C20, 16'h8000, 16'h8000, 16, 1'b0);
        trigger();
        rd(2'd1, 5'd7, rv);
        chk("ovw_rf17", rv, 8'h20);
        chk("ovw_active", ACTIVE, (128'h1 << 39) | 128'h8);
        // CSb rise and TRG rise in the same detect cycle: lane2 addr1 0x33
        mark();
        send_frame(16'h8000, 16'h8000, 16'h8433, 16'h8000, 16, 1'b1);
        chk("sim_wv", wv_cnt - wv0, 1);
        chk("sim_apply", ap_cnt - ap0, 1);
        rd(2'd2, 5'd1, rv);
        chk("sim_rf21", rv, 8'h33);
        chk("sim_active", ACTIVE, (128'h1 << 65) | (128'h1 << 39) | 128'h8);
        // soft reset keeps ERR_CNT
        send_frame(16'h8000, 16'h8000, 16'h8000, 16'h8000, 15, 1'b0);
        chk("srst_errcnt_pre", ERR_CNT, 3);
        RST_SLV = 1'b1;
        #60 RST_SLV = 1'b0;
        #60;
        chk("srst_active", ACTIVE, '0);
        chk("srst_bias", {BIAS_SEL, BIAS_AMP}, 0);
        chk("srst_errcnt", ERR_CNT, 3);
        rd(2'd0, 5'd3, rv);
        chk("srst_rf03", rv, 0);
        // hard reset mid-frame, then a full frame: lane3 addr31 0xFF
        mark();
        CSb = 1'b0;
        #80;
        for (int i = 0; i < 8; i++) begin
            MOSI = 4'hF;
            #40 SCLK = 1'b1;
            #40 SCLK = 1'b0;
        end
        RST = 1'b0;
        #40 RST = 1'b1;
        #40 CSb = 1'b1;
        #100;
        send_frame(16'h8000, 16'h8000, 16'h8000, 16'hFCFF, 16, 1'b0);
        chk("midrst_fe", fe_cnt - fe0, 0);
        chk("midrst_wv", wv_cnt - wv0, 1);
        chk("midrst_errcnt", ERR_CNT, 0);
        trigger();
        rd(2'd3, 5'd31, rv);
        chk("midrst_rf331", rv, 8'hFF);
        chk("midrst_active", ACTIVE, 128'h1 << 127);
        // error counter saturation
        mark();
        for (int i = 0; i < 260; i++) send_frame(16'h0, 16'h0, 16'h0, 16'h0, 1, 1'b0);
        chk("sat_fe", fe_cnt - fe0, 260);
        chk("sat_errcnt", ERR_CNT, 8'd255);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
